// File: rtl/frame_step_controller.sv
// frame_step_controller: turns ticks and manual steps into frame advances delivered over a
// 4-phase req/ack handshake, with one pending slot and a saturating overrun counter.
module frame_step_controller #(
    parameter int FRAME_COUNT = 8,
    parameter int INDEX_WIDTH = 4,
    parameter bit PINGPONG    = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   run,
    input  logic                   step,
    input  logic                   clear_stats,
    input  logic                   step_ack,
    output logic                   step_req,
    output logic [INDEX_WIDTH-1:0] frame_index,
    output logic                   direction,
    output logic                   busy,
    output logic [7:0]             missed_ticks
);
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(FRAME_COUNT - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE  = INDEX_WIDTH'(1);
    state_t state, state_next;
    logic ev, go, miss, pending, pending_next, dir_next;
    logic [INDEX_WIDTH-1:0] index_next;
    assign ev = (tick & run) | step;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            step_req <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            step_req <= state_next == REQ;
            busy     <= state_next != IDLE;
        end
    end
    always_comb begin
        go = (state == IDLE) ? (ev | pending) :
             (state == RELEASE) ? (!step_ack & (ev | pending)) : 1'b0;
        state_next = go ? REQ :
                     (state == REQ && step_ack) ? RELEASE :
                     (state == RELEASE && !step_ack) ? IDLE : state;
    end
    // A RELEASE->REQ that consumes pending re-arms it if a fresh event lands on the same edge
    always_comb begin
        pending_next = go ? (pending & ev & (state == RELEASE)) : (pending | (ev & (state != IDLE)));
        miss         = ev & pending & (state != IDLE) & !go;
        index_next   = '0;
        dir_next     = 1'b0;
        if (!PINGPONG) begin
            index_next = (frame_index == LAST) ? '0 : frame_index + ONE;
        end else if (FRAME_COUNT > 1) begin
            if (!direction) begin
                index_next = (frame_index == LAST) ? LAST - ONE : frame_index + ONE;
                dir_next   = frame_index == LAST;
            end else begin
                index_next = (frame_index == '0) ? ONE : frame_index - ONE;
                dir_next   = frame_index != '0;
            end
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_index  <= '0;
            direction    <= 1'b0;
            pending      <= 1'b0;
            missed_ticks <= '0;
        end else begin
            if (go) begin
                frame_index <= index_next;
                direction   <= dir_next;
            end
            pending      <= pending_next;
            missed_ticks <= clear_stats ? 8'd0 :
                            (miss && missed_ticks != 8'hff) ? missed_ticks + 8'd1 : missed_ticks;
        end
    end
endmodule

// File: tb/tb_frame_step_controller.sv
// tb_frame_step_controller: directed checks of a wrapping (8 frames) and a ping-pong (4 frames) instance.
module tb_frame_step_controller;
    logic clock = 1'b0, reset = 1'b0, tick = 1'b0, run = 1'b0, step = 1'b0, clear_stats = 1'b0;
    logic hold = 1'b0, ack_a = 1'b0, ack_b = 1'b0;
    logic req_a, req_b, dir_a, dir_b, busy_a, busy_b;
    logic [3:0] idx_a, idx_b;
    logic [7:0] miss_a, miss_b;
    int checks = 0, fails = 0;
    int pp_idx[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int pp_dir[8] = '{0, 0, 0, 1, 1, 1, 0, 0};

    frame_step_controller dut_a (
        .clock(clock), .reset(reset), .tick(tick), .run(run), .step(step),
        .clear_stats(clear_stats), .step_ack(ack_a), .step_req(req_a), .frame_index(idx_a),
        .direction(dir_a), .busy(busy_a), .missed_ticks(miss_a)
    );
    frame_step_controller #(.FRAME_COUNT(4), .INDEX_WIDTH(4), .PINGPONG(1'b1)) dut_b (
        .clock(clock), .reset(reset), .tick(tick), .run(run), .step(step),
        .clear_stats(clear_stats), .step_ack(ack_b), .step_req(req_b), .frame_index(idx_b),
        .direction(dir_b), .busy(busy_b), .missed_ticks(miss_b)
    );

    always #10 clock = ~clock;

    // Engine model: ack follows req one cycle later unless stalled
    always @(negedge clock) begin
        ack_a = hold ? 1'b0 : req_a;
        ack_b = hold ? 1'b0 : req_b;
    end

    task check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task pulse(input logic t, input logic s);
        tick = t;
        step = s;
        @(negedge clock);
        tick = 1'b0;
        step = 1'b0;
    endtask

    task wait_idle;
        int n = 0;
        while ((busy_a | busy_b) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("idle", busy_a | busy_b, 0);
    endtask

    task wait_req(input logic v);
        int n = 0;
        while (req_a !== v && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("wait_req", req_a, v);
    endtask

    task do_reset;
        hold = 1'b0;
        reset = 1'b0;
        cyc(2);
        check("rst_req", req_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_dir", dir_b, 0);
        check("rst_miss", miss_a, 0);
        reset = 1'b1;
        cyc(1);
    endtask

    initial begin
        cyc(1);
        do_reset;
        run = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            pulse(1'b1, 1'b0);
            if (i == 1) check("wrap_req", req_a, 1);
            check("wrap_idx", idx_a, i % 8);
            wait_idle;
        end
        check("wrap_miss", miss_a, 0);

        do_reset;
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, 1'b0);
            check("pp_idx", idx_b, pp_idx[i]);
            check("pp_dir", dir_b, pp_dir[i]);
            wait_idle;
        end
        check("wrap_dir", dir_a, 0);

        do_reset;
        hold = 1'b1;
        pulse(1'b1, 1'b0);
        check("stall_idx", idx_a, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(20);
            pulse(1'b1, 1'b0);
        end
        cyc(16);
        check("stall_miss", miss_a, 3);
        check("stall_req", req_a, 1);
        check("stall_hold_idx", idx_a, 1);
        hold = 1'b0;
        wait_req(1'b0);
        wait_req(1'b1);
        check("pend_idx", idx_a, 2);
        wait_idle;
        hold = 1'b1;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("miss_4", miss_a, 4);
        tick = 1'b1;
        clear_stats = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        clear_stats = 1'b0;
        check("clear_prio", miss_a, 0);
        hold = 1'b0;
        wait_idle;

        do_reset;
        run = 1'b0;
        pulse(1'b1, 1'b0);
        cyc(2);
        check("norun_req", req_a, 0);
        check("norun_idx", idx_a, 0);
        pulse(1'b0, 1'b1);
        check("step_req", req_a, 1);
        check("step_idx", idx_a, 1);
        wait_idle;
        run = 1'b1;
        pulse(1'b1, 1'b1);
        check("both_idx", idx_a, 2);
        wait_idle;
        cyc(3);
        check("both_once_idx", idx_a, 2);
        check("both_once_busy", busy_a, 0);
        check("both_miss", miss_a, 0);

        hold = 1'b1;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("pre_rst_miss", miss_a, 1);
        check("pre_rst_req", req_a, 1);
        reset = 1'b0;
        #1;
        check("async_req", req_a, 0);
        check("async_idx", idx_a, 0);
        check("async_miss", miss_a, 0);
        check("async_busy", busy_a, 0);
        @(negedge clock);
        reset = 1'b1;
        hold = 1'b0;
        cyc(2);
        check("no_pend_req", req_a, 0);
        pulse(1'b1, 1'b0);
        check("post_rst_idx", idx_a, 1);
        wait_idle;

        hold = 1'b1;
        pulse(1'b1, 1'b0);
        tick = 1'b1;
        cyc(300);
        tick = 1'b0;
        check("sat_miss", miss_a, 255);
        hold = 1'b0;
        wait_idle;
        check("sat_idx", idx_a, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/frame_step_controller.md
# frame_step_controller

- Downstream consumer of the square-wave generator's `rising_edge` pulse.
- Converts each tick, or each manual step pulse, into one frame advance of the rendering engine.
- Delivers each advance over a 4-phase req/ack handshake, holding the frame index stable for the whole transaction.
- Buffers one pending event while a handshake is in flight and counts events lost to overrun.

## Interface
Parameters:
- FRAME_COUNT, 8, number of frames in the sequence; legal range 1..2^INDEX_WIDTH
- INDEX_WIDTH, 4, width of frame_index
- PINGPONG, 0, 0 = wrap upward; 1 = bounce between 0 and FRAME_COUNT-1

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset; one clock domain
- tick  in  1  one-cycle pulse from the square-wave generator's rising_edge
- run  in  1  1 = ticks generate events; 0 = ticks ignored
- step  in  1  one-cycle manual advance pulse; effective regardless of run
- clear_stats  in  1  one-cycle pulse; zeroes missed_ticks
- step_ack  in  1  acknowledge from the engine
- step_req  out  1  frame-advance request
- frame_index  out  INDEX_WIDTH  current frame number
- direction  out  1  0 = counting up, 1 = counting down; always 0 when PINGPONG=0
- busy  out  1  high in REQ or RELEASE
- missed_ticks  out  8  saturating count of dropped events

## Operation
Events and pending buffer:
- event = (tick & run) | step. Simultaneous tick and step count as one event.

State machine, encoding IDLE / REQ / RELEASE:
- IDLE:
  - On event or pending=1, advance the index, clear pending, and go to REQ.
- REQ:
  - step_req=1 and frame_index held stable.
  - When step_ack=1 is sampled, go to RELEASE.
- RELEASE:
  - step_req=0; wait for step_ack=0.
  - Once step_ack=0: if pending=1 or event, advance, clear pending, go to REQ; else go to IDLE.
- An event in REQ or RELEASE that is not consumed on that edge:
  - If pending=0, set pending.
  - If pending=1, increment missed_ticks, saturating at 255.
- On a RELEASE→REQ transition that consumes pending while a new event arrives the same cycle, the new event sets pending; nothing is missed.

Index advance:
- PINGPONG=0: FRAME_COUNT-1 wraps to 0; otherwise +1.
- PINGPONG=1, counting up:
  - At FRAME_COUNT-1, set direction=1 and go to FRAME_COUNT-2.
  - Otherwise +1.
- PINGPONG=1, counting down:
  - At 0, set direction=0 and go to 1.
  - Otherwise -1.
- FRAME_COUNT=1: index stays 0 and direction stays 0; handshakes still occur.

Controls:
- clear_stats has priority over a simultaneous missed-event increment; the result is 0.
- Deasserting run does not cancel an in-flight handshake or a pending event.

## Timing
- Reset asserted, at any time including mid-handshake, takes effect immediately:
  - state=IDLE, step_req=0, busy=0
  - frame_index=0, direction=0
  - pending=0, missed_ticks=0
- All outputs are registered.
- Latency and handshake timing:
  - An event sampled in IDLE at edge N gives step_req=1 and the new frame_index after edge N.
  - step_ack sampled high at edge M gives step_req=0 after edge M.
  - step_ack sampled low in RELEASE at edge K gives IDLE, or step_req=1 again, after edge K.
- frame_index and direction change only on the IDLE→REQ or RELEASE→REQ edge.
- step_ack high in IDLE is ignored.
- Throughput: one frame per 2 cycles plus the engine's ack latency.

## Test plan
- Reset, run=1, FRAME_COUNT=8, PINGPONG=0, engine acks 1 cycle after req and drops ack 1 cycle after req falls; 10 ticks → frame_index 1,2,…,7,0,1,2; missed_ticks=0.
- PINGPONG=1, FRAME_COUNT=4; 8 ticks → frame_index sequence 1,2,3,2,1,0,1,2; direction flips after the transitions to 3 and to 0.
- Engine withholds ack for 100 cycles while 4 ticks arrive → one pending event is served immediately after release; missed_ticks=3. Then clear_stats pulsed together with a 5th overrun tick → missed_ticks=0.
- run=0: ticks produce no step_req. A step pulse gives step_req=1 the next cycle. tick and step in the same cycle give exactly one advance.
- Reset asserted while step_req=1 and pending=1 → step_req, frame_index, and missed_ticks are 0 immediately; the first tick after release gives frame_index=1.
- Drive 300 overrun events during one stalled handshake → missed_ticks saturates at 255.
